aref_ctrl: RTL

//  SDRAM auto-refresh generator. Sits directly downstream of the power-up init

---
 rtl/aref_ctrl.sv | 134 +++++++++++++
 1 files changed

// File: rtl/aref_ctrl.sv
// SDRAM auto-refresh generator: requests a refresh every REF_INTERVAL clocks after
// init, then issues PRECHARGE-all plus AREF_NUM AUTO_REFRESH commands once granted.
//
// state  | meaning
// IDLE   | waiting for the refresh interval / grant
// PCHA   | PRECHARGE-all issued
// TRP    | precharge recovery, TRP_CLK NOPs
// AREF   | AUTO_REFRESH issued
// TRF    | refresh recovery, TRC_CLK NOPs
// END    | aref_end pulse, bus released
module aref_ctrl #(
  parameter int REF_INTERVAL = 750,
  parameter int TRP_CLK      = 2,
  parameter int TRC_CLK      = 7,
  parameter int AREF_NUM     = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        init_end_flag,
  input  logic        aref_en,
  output logic        aref_req,
  output logic [3:0]  aref_cmd,
  output logic [1:0]  aref_ba,
  output logic [11:0] aref_addr,
  output logic        aref_end
);

  localparam int REF_W = $clog2(REF_INTERVAL);
  localparam int CLK_W = $clog2(((TRP_CLK > TRC_CLK) ? TRP_CLK : TRC_CLK) + 1);

  localparam logic [REF_W-1:0] REF_LAST  = REF_W'(REF_INTERVAL - 1);
  localparam logic [CLK_W-1:0] TRP_LAST  = CLK_W'(TRP_CLK - 1);
  localparam logic [CLK_W-1:0] TRC_LAST  = CLK_W'(TRC_CLK - 1);
  localparam logic [2:0]       AREF_LAST = 3'(AREF_NUM);

  localparam logic [3:0] CMD_NOP  = 4'b0111;
  localparam logic [3:0] CMD_PCHA = 4'b0010;
  localparam logic [3:0] CMD_AREF = 4'b0001;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PCHA = 3'd1,
    S_TRP  = 3'd2,
    S_AREF = 3'd3,
    S_TRF  = 3'd4,
    S_END  = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [REF_W-1:0] cnt_ref_q, cnt_ref_d;
  logic [CLK_W-1:0] cnt_clk_q, cnt_clk_d;
  logic [2:0]       aref_cnt_q, aref_cnt_d;
  logic             req_q, req_d;
  logic             end_q, end_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [1:0]       ba_q, ba_d;
  logic [11:0]      addr_q, addr_d;
  logic             grant;

  always_ff @(posedge sys_clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state_q    <= S_IDLE;
      cnt_ref_q  <= '0;
      cnt_clk_q  <= '0;
      aref_cnt_q <= '0;
      req_q      <= 1'b0;
      end_q      <= 1'b0;
      cmd_q      <= CMD_NOP;
      ba_q       <= 2'b11;
      addr_q     <= 12'h400;
    end else begin
      state_q    <= state_d;
      cnt_ref_q  <= cnt_ref_d;
      cnt_clk_q  <= cnt_clk_d;
      aref_cnt_q <= aref_cnt_d;
      req_q      <= req_d;
      end_q      <= end_d;
      cmd_q      <= cmd_d;
      ba_q       <= ba_d;
      addr_q     <= addr_d;
    end
  end

  always_comb begin
    grant      = (state_q == S_IDLE) && req_q && aref_en;
    state_d    = state_q;
    cnt_ref_d  = cnt_ref_q;
    cnt_clk_d  = '0;
    aref_cnt_d = aref_cnt_q;
    req_d      = req_q;
    end_d      = 1'b0;
    cmd_d      = CMD_NOP;
    ba_d       = 2'b11;
    addr_d     = 12'h400;

    case (state_q)
      S_IDLE:  if (grant) state_d = S_PCHA;
      S_PCHA:  state_d = S_TRP;
      S_TRP:   if (cnt_clk_q == TRP_LAST) state_d = S_AREF;
      S_AREF:  state_d = S_TRF;
      S_TRF:   if (cnt_clk_q == TRC_LAST)
                 state_d = (aref_cnt_q == AREF_LAST) ? S_END : S_AREF;
      S_END:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == state_q) cnt_clk_d = cnt_clk_q + 1'b1;

    if (state_q == S_IDLE)      aref_cnt_d = '0;
    else if (state_q == S_AREF) aref_cnt_d = aref_cnt_q + 1'b1;

    // Interval runs grant-to-request; saturating keeps a pending request single.
    if (!init_end_flag || grant)   cnt_ref_d = '0;
    else if (cnt_ref_q != REF_LAST) cnt_ref_d = cnt_ref_q + 1'b1;

    if (grant)                       req_d = 1'b0;
    else if (cnt_ref_q == REF_LAST)  req_d = 1'b1;

    // Outputs are registered from the next state so commands line up with the state.
    case (state_d)
      S_PCHA:  cmd_d = CMD_PCHA;
      S_AREF:  cmd_d = CMD_AREF;
      default: cmd_d = CMD_NOP;
    endcase
    end_d = (state_d == S_END);
  end

  assign aref_req  = req_q;
  assign aref_cmd  = cmd_q;
  assign aref_ba   = ba_q;
  assign aref_addr = addr_q;
  assign aref_end  = end_q;

endmodule
